// File: rtl/prbs_pkg.sv
// Shared PRBS-31 definitions: word width, feedback taps, the word-step
// function used by both generator and checker, and the checker state encoding.
package prbs_pkg;

  localparam int PRBS_WIDTH = 32;
  localparam int PRBS_TAP1  = 30;
  localparam int PRBS_TAP2  = 27;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Advance one full word: PRBS_WIDTH serial LFSR steps, newest bit enters at bit 0.
  function automatic logic [PRBS_WIDTH-1:0] prbs_step(
    input logic [PRBS_WIDTH-1:0] w,
    input int                    tap1,
    input int                    tap2
  );
    logic [PRBS_WIDTH-1:0] d;
    d = w;
    for (int i = 0; i < PRBS_WIDTH; i++) begin
      d = {d[PRBS_WIDTH-2:0], d[tap1] ^ d[tap2]};
    end
    return d;
  endfunction

endpackage

// File: rtl/prbs_checker_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module prbs_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Sum of all set bits; synthesis balances this into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-31 checker: hunts for a seed, verifies LOCK_CNT
// consecutive matches, then free-runs its own sequence and counts bit errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH     = PRBS_WIDTH,
  parameter int TAP1      = PRBS_TAP1,
  parameter int TAP2      = PRBS_TAP2,
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_BITS = 8,
  parameter int LOSS_CNT  = 4,
  parameter int CNT_W     = 48
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_valid,
  input  logic                       clear_counts,
  output logic                       locked,
  output logic [$clog2(WIDTH+1)-1:0] word_errs,
  output logic                       word_err,
  output logic [CNT_W-1:0]           bit_count,
  output logic [CNT_W-1:0]           err_count
);

  localparam int EW  = $clog2(WIDTH + 1);
  localparam int MW  = $clog2(LOCK_CNT + 1);
  localparam int BW  = $clog2(LOSS_CNT + 1);
  localparam int CW1 = CNT_W + 1;

  chk_state_e       state, state_nxt;
  logic [WIDTH-1:0] seed_q, seed_nxt;
  logic [WIDTH-1:0] err_vec_q, err_vec_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [BW-1:0]    bad_cnt, bad_nxt;
  logic             chk_q, chk_nxt;
  logic             locked_nxt;
  logic [WIDTH-1:0] expected;
  logic [EW-1:0]    live_errs;
  logic [EW-1:0]    vec_errs;
  logic             bad_word;
  logic [CW1-1:0]   bit_sum;
  logic [CW1-1:0]   err_sum;

  // The shared step function is defined at the package width; WIDTH must match it.
  assign expected = prbs_step(seed_q, TAP1, TAP2);
  assign bad_word = (live_errs > EW'(LOSS_BITS));

  prbs_popcount #(.WIDTH(WIDTH)) u_live_pop (
    .bits  (data_in ^ expected),
    .count (live_errs)
  );

  prbs_popcount #(.WIDTH(WIDTH)) u_vec_pop (
    .bits  (err_vec_q),
    .count (vec_errs)
  );

  // Next-state logic; only valid words advance the FSM.
  always_comb begin
    state_nxt   = state;
    seed_nxt    = seed_q;
    err_vec_nxt = err_vec_q;
    match_nxt   = match_cnt;
    bad_nxt     = bad_cnt;
    chk_nxt     = 1'b0;
    if (data_valid) begin
      case (state)
        HUNT: begin
          seed_nxt  = data_in;
          match_nxt = '0;
          state_nxt = VERIFY;
        end
        VERIFY: begin
          seed_nxt = data_in;
          if (data_in == expected) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state_nxt = LOCKED;
              match_nxt = '0;
              bad_nxt   = '0;
            end else begin
              match_nxt = match_cnt + MW'(1);
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          // Free-run: never re-seed from data, so one flipped bit stays one error.
          seed_nxt    = expected;
          err_vec_nxt = data_in ^ expected;
          chk_nxt     = 1'b1;
          if (bad_word) begin
            if (bad_cnt == BW'(LOSS_CNT - 1)) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_cnt + BW'(1);
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  assign locked_nxt = (state_nxt == LOCKED);

  // FSM and sequence registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      seed_q    <= '0;
      err_vec_q <= '0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      chk_q     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      seed_q    <= seed_nxt;
      err_vec_q <= err_vec_nxt;
      match_cnt <= match_nxt;
      bad_cnt   <= bad_nxt;
      chk_q     <= chk_nxt;
      locked    <= locked_nxt;
    end
  end

  assign bit_sum = {1'b0, bit_count} + CW1'(WIDTH);
  assign err_sum = {1'b0, err_count} + CW1'(vec_errs);

  // Per-word error report and saturating totals, one edge after the word was checked.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_errs <= '0;
      word_err  <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
    end else begin
      if (chk_q) begin
        word_errs <= vec_errs;
        word_err  <= (vec_errs != EW'(0));
      end else begin
        word_err  <= 1'b0;
      end
      if (clear_counts) begin
        bit_count <= '0;
        err_count <= '0;
      end else if (chk_q) begin
        bit_count <= bit_sum[CNT_W] ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
        err_count <= err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
      end else begin
        bit_count <= bit_count;
        err_count <= err_count;
      end
    end
  end

endmodule
